// File: rtl/interp_filt_pkg.sv
// Shared types and constants for the interp_filt sequencer: FSM encoding, default widths, counter sizing.
package interp_filt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_e;

    localparam int IN_W_DEF     = 4;
    localparam int OUT_W_DEF    = 16;
    localparam int SAMPLE_CNT_W = 16;

    function automatic int settle_cnt_w(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/interp_filt_ctrl_if.sv
// Sample-in / result-out handshakes plus the filter A/Z pins; slave is the sequencer side.
interface interp_filt_ctrl_if #(
    parameter int IN_W  = interp_filt_pkg::IN_W_DEF,
    parameter int OUT_W = interp_filt_pkg::OUT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  filt_a;
    logic [OUT_W-1:0] filt_z;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, filt_z, out_ready,
        output in_ready, filt_a, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, filt_z, out_ready,
        input  in_ready, filt_a, out_valid, out_data
    );
endinterface

// File: rtl/interp_filt_settle_cnt.sv
// Loadable down-counter timing the filter settle window; load value is FILT_LAT, one-cycle update.
module interp_filt_settle_cnt #(
    parameter int FILT_LAT = 0,
    parameter int CNT_W    = interp_filt_pkg::settle_cnt_w(FILT_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(FILT_LAT);
        end else if (dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);
endmodule

// File: rtl/interp_filt_ctrl.sv
// Drives a sample onto filter A, waits FILT_LAT cycles, captures Z; result valid FILT_LAT+3 cycles after accept.
// Result and A held until out_ready, no sample accepted meanwhile; INTERP_FILT_CTRL_SAMPLE_CNT_EN adds sample_cnt.
module interp_filt_ctrl import interp_filt_pkg::*; #(
    parameter int IN_W     = IN_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int FILT_LAT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    interp_filt_ctrl_if.slave       bus,
    output logic                    busy
`ifdef INTERP_FILT_CTRL_SAMPLE_CNT_EN
    ,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt
`endif
);
    localparam int CNT_W = settle_cnt_w(FILT_LAT);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  filt_a_q, filt_a_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_fire, out_fire;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    assign in_fire  = bus.in_valid && (state_q == IDLE) && !rst;
    assign out_fire = out_valid_q && bus.out_ready;

    interp_filt_settle_cnt #(.FILT_LAT(FILT_LAT), .CNT_W(CNT_W)) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_fire)  state_d = SETTLE;
            SETTLE:  if (cnt_zero) state_d = CAPTURE;
            CAPTURE: state_d = OUT;
            OUT:     if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE) && !rst;
        busy         = (state_q != IDLE);
        cnt_load     = in_fire;
        cnt_dec      = (state_q == SETTLE) && (cnt_value != '0);
    end

    // A is only ever reloaded on acceptance, so it stays put through SETTLE/CAPTURE/OUT.
    always_comb begin
        filt_a_d    = in_fire ? bus.in_data : filt_a_q;
        out_data_d  = (state_q == CAPTURE) ? bus.filt_z : out_data_q;
        out_valid_d = out_valid_q;
        if (state_q == CAPTURE) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_a_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            filt_a_q    <= filt_a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.filt_a    = filt_a_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

`ifdef INTERP_FILT_CTRL_SAMPLE_CNT_EN
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;

    always_comb begin
        sample_cnt_d = out_fire ? sample_cnt_q + 1'b1 : sample_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
`endif
endmodule

// File: doc/interp_filt_ctrl.md
Name: interp_filt_ctrl

Overview:
Sequencer in front of the interp_filt datapath. It accepts 4-bit samples over a valid/ready handshake and drives them onto the filter input A. It waits a programmable settle time, captures the 16-bit filter output Z, and presents it downstream over a second valid/ready handshake. This gives the filter (or a later pipelined version of it) a flow-controlled, registered interface.

Parameters:
- IN_W, 4, sample width; matches filter A.
- OUT_W, 16, result width; matches filter Z.
- FILT_LAT, 0, extra cycles A must be held stable before Z is captured (0 = combinational filter).

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  IN_W  upstream sample.
- filt_a  out  IN_W  registered drive to filter A.
- filt_z  in  OUT_W  filter Z.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  registered captured result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst sampled high at a posedge): state=IDLE, filt_a=0, out_data=0, out_valid=0, settle counter=0. in_ready is 0 while rst is high.
- Reset mid-operation abandons the in-flight sample; nothing is emitted for it.
- FSM states: IDLE, SETTLE, CAPTURE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: filt_a<=in_data, cnt<=FILT_LAT, go SETTLE.
  - With no in_valid, stay in IDLE.
- SETTLE:
  - If cnt==0, go CAPTURE; else cnt<=cnt-1.
  - filt_a is held constant.
- CAPTURE: out_data<=filt_z, out_valid<=1, go OUT.
- OUT:
  - out_valid=1; out_data and filt_a are held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go IDLE.
  - out_ready may be held high in advance; the transfer then occurs on the first OUT cycle.
- in_ready=0 in SETTLE, CAPTURE and OUT. in_valid in those states is ignored and its data is not consumed.
- Latency: the acceptance edge is cycle 0; out_valid rises at cycle FILT_LAT+3.
- Minimum period per sample: FILT_LAT+4 cycles with out_ready tied high.
- in_valid with out_ready both high in OUT: only the output transfer occurs. The new sample is accepted on the next cycle, in IDLE.
- Counter width: max(1, clog2(FILT_LAT+1)). No wrap is possible because the counter only decrements from FILT_LAT to 0.
- out_data is a direct capture of filt_z, with no width conversion.
- busy = (state != IDLE).

Optional Feature:
- Macro: INTERP_FILT_CTRL_SAMPLE_CNT_EN.
- Defined:
  - Adds output port sample_cnt [15:0], reset to 0.
  - Increments on each out_valid&&out_ready transfer.
  - Wraps 16'hFFFF -> 16'h0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package interp_filt_pkg holds:
  - the state encoding (IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2, OUT=2'd3);
  - IN_W/OUT_W defaults;
  - sample counter width constant SAMPLE_CNT_W=16.
- One sub-module, interp_filt_settle_cnt: a loadable down-counter with load, value and zero-flag ports, parameterised by FILT_LAT.
- The FSM stays in interp_filt_ctrl.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, filt_a=0, out_data=0 during reset; in_ready=1 on the first cycle after rst is released.
- Single transfer, FILT_LAT=0:
  - Setup: filt_z stub = {A,A,A,A}; in_data=4'h5 accepted at cycle 0; out_ready=1.
  - Expect: filt_a=4'h5 from cycle 1; out_valid at cycle 3 with out_data=16'h5555; back in IDLE at cycle 4.
- Back-pressure:
  - Setup: in_data=4'hA, out_ready=0 for 10 cycles after out_valid rises.
  - Expect: out_valid stays high, out_data=16'hAAAA and filt_a=4'hA stay stable, in_ready=0 throughout.
  - Then out_ready=1 -> one transfer, then IDLE.
- Settle latency, FILT_LAT=3:
  - Setup: stub Z updates 3 cycles after A changes; in_data=4'h7.
  - Expect: out_valid at cycle 6 with out_data=16'h7777, and no stale value from the previous A.
- Stream 0..15 with in_valid and out_ready held high:
  - Expect: 16 results, 16'h0000 … 16'hFFFF, in order.
  - Expect: accept spacing of FILT_LAT+4 cycles.
  - Expect: in_valid never consumed while in_ready=0.
- Reset mid-op: assert rst in SETTLE with in_data=4'h3 in flight -> no out_valid for that sample; next sample 4'h9 yields 16'h9999. With INTERP_FILT_CTRL_SAMPLE_CNT_EN, sample_cnt=0 after reset and 1 after the 4'h9 transfer.
